// File: rtl/qlab5_sys_pio_seq.sv
// qlab5_sys_pio_seq
//
// Avalon-MM write-only master that drives the single-bit PIO output port of
// the qlab5 system. It produces a train of repeat_cnt pulses. Each pulse is
// on_cycles clocks high followed by off_cycles clocks low. The pulses are made
// by set writes (address 4) and clear writes (address 5) to the PIO s1 slave.
// After reset it first writes 0 to the data register (address 0). This
// overrides the PIO reset value of 1.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          request a pulse train (sampled only in IDLE)
//   abort          end the running train early
//   on_cycles      high time in clocks (0 treated as 1), latched at start
//   off_cycles     low time in clocks (0 treated as 1), latched at start
//   repeat_cnt     number of pulses, latched at start
//   pio_address    Avalon address to the PIO
//   pio_chipselect Avalon chipselect to the PIO
//   pio_write_n    Avalon write strobe, active low
//   pio_writedata  Avalon writedata to the PIO
//   busy           high whenever a train (or the power-up write) is in flight
//   done           one-clock pulse when a train ends
//   pulses_done    pulses completed in the current/last train

module qlab5_sys_pio_seq #(
  parameter int          CNT_W    = 24,
  parameter int          REP_W    = 8,
  parameter logic [31:0] PIO_MASK = 32'h1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] on_cycles,
  input  logic [CNT_W-1:0] off_cycles,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic [2:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] pulses_done
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SET_WR,
    ON_WAIT,
    CLR_WR,
    OFF_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               armed_q;
  logic [CNT_W-1:0]   onLen_q, onLen_d;
  logic [CNT_W-1:0]   offLen_q, offLen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REP_W-1:0]   repeat_q, repeat_d;
  logic [REP_W-1:0]   pulsesDone_q, pulsesDone_d;
  logic               pulseOpen_q, pulseOpen_d;
  logic               abortEnd_q, abortEnd_d;
  logic               done_q, done_d;
  logic               zeroBusy_q, zeroBusy_d;
  logic [REP_W-1:0]   nextCount;
  logic               lastPulse;

  // armed_q stays low from reset until the first clock edge. The INIT write
  // is qualified by it, so the Avalon outputs keep their idle values while
  // reset_n is low. The write then shows up in the first clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT;
      onLen_q      <= '0;
      offLen_q     <= '0;
      cnt_q        <= '0;
      repeat_q     <= '0;
      pulsesDone_q <= '0;
      pulseOpen_q  <= 1'b0;
      abortEnd_q   <= 1'b0;
      done_q       <= 1'b0;
      zeroBusy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      onLen_q      <= onLen_d;
      offLen_q     <= offLen_d;
      cnt_q        <= cnt_d;
      repeat_q     <= repeat_d;
      pulsesDone_q <= pulsesDone_d;
      pulseOpen_q  <= pulseOpen_d;
      abortEnd_q   <= abortEnd_d;
      done_q       <= done_d;
      zeroBusy_q   <= zeroBusy_d;
    end
  end

  assign nextCount = pulsesDone_q + 1'b1;

  // A clear write counts as a completed pulse only if it closes a set.
  // An abort during OFF_WAIT leads to a clear with no open pulse, so that
  // clear must not count.
  assign lastPulse = pulseOpen_q && (nextCount == repeat_q);

  // Next-state logic. The duration counter holds the remaining wait cycles.
  // It is loaded with len-1 in the write state, so that the high/low times
  // come out as exactly len clocks, counting the write cycle itself.
  always_comb begin
    state_d      = state_q;
    onLen_d      = onLen_q;
    offLen_d     = offLen_q;
    cnt_d        = cnt_q;
    repeat_d     = repeat_q;
    pulsesDone_d = pulsesDone_q;
    pulseOpen_d  = pulseOpen_q;
    abortEnd_d   = abortEnd_q;
    done_d       = 1'b0;
    zeroBusy_d   = 1'b0;

    case (state_q)
      INIT: begin
        if (armed_q) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (start) begin
          onLen_d      = (on_cycles == '0) ? CNT_W'(1) : on_cycles;
          offLen_d     = (off_cycles == '0) ? CNT_W'(1) : off_cycles;
          repeat_d     = repeat_cnt;
          pulsesDone_d = '0;
          pulseOpen_d  = 1'b0;
          abortEnd_d   = 1'b0;
          if (repeat_cnt == '0) begin
            done_d     = 1'b1;
            zeroBusy_d = 1'b1;
          end else begin
            state_d = SET_WR;
          end
        end
      end

      SET_WR: begin
        pulseOpen_d = 1'b1;
        cnt_d       = onLen_q - 1'b1;
        if (abort) begin
          abortEnd_d = 1'b1;
          state_d    = CLR_WR;
        end else if (onLen_q == CNT_W'(1)) begin
          state_d = CLR_WR;
        end else begin
          state_d = ON_WAIT;
        end
      end

      ON_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (abort) begin
          abortEnd_d = 1'b1;
          state_d    = CLR_WR;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = CLR_WR;
        end
      end

      CLR_WR: begin
        pulseOpen_d = 1'b0;
        if (pulseOpen_q) begin
          pulsesDone_d = nextCount;
        end
        if (abortEnd_q || abort || lastPulse) begin
          abortEnd_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = offLen_q - 1'b1;
          if (offLen_q == CNT_W'(1)) begin
            state_d = SET_WR;
          end else begin
            state_d = OFF_WAIT;
          end
        end
      end

      OFF_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (abort) begin
          abortEnd_d = 1'b1;
          state_d    = CLR_WR;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = SET_WR;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Avalon outputs are decoded straight from the state. Each write state
  // therefore strobes for exactly one cycle, and the bus is idle otherwise.
  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = 3'd0;
    pio_writedata  = 32'd0;
    case (state_q)
      INIT: begin
        if (armed_q) begin
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
        end
      end
      SET_WR: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = 3'd4;
        pio_writedata  = PIO_MASK;
      end
      CLR_WR: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = 3'd5;
        pio_writedata  = PIO_MASK;
      end
      default: begin
        pio_chipselect = 1'b0;
      end
    endcase
  end

  // A zero-length train never leaves IDLE. zeroBusy_q keeps busy high for
  // its single done cycle.
  assign busy        = zeroBusy_q || ((state_q != IDLE) && !((state_q == INIT) && !armed_q));
  assign done        = done_q;
  assign pulses_done = pulsesDone_q;

endmodule

// File: tb/tb_qlab5_sys_pio_seq.sv
// Testbench for qlab5_sys_pio_seq.
// Drives directed scenarios and checks the Avalon bus, busy, done and
// pulses_done on every falling edge. A small behavioural model of the PIO
// output register tracks the resulting port level.

module tb_qlab5_sys_pio_seq;

  localparam int          CNT_W = 24;
  localparam int          REP_W = 8;
  localparam logic [31:0] MASK  = 32'h1;

  localparam logic [36:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 32'd0};
  localparam logic [36:0] BUS_INIT = {1'b1, 1'b0, 3'd0, 32'd0};
  localparam logic [36:0] BUS_SET  = {1'b1, 1'b0, 3'd4, MASK};
  localparam logic [36:0] BUS_CLR  = {1'b1, 1'b0, 3'd5, MASK};

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] on_cycles;
  logic [CNT_W-1:0] off_cycles;
  logic [REP_W-1:0] repeat_cnt;
  logic [2:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulses_done;

  logic             pioOut;
  logic [36:0]      actBus;
  int               checkCount;
  int               passCount;

  qlab5_sys_pio_seq #(
    .CNT_W   (CNT_W),
    .REP_W   (REP_W),
    .PIO_MASK(MASK)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .on_cycles     (on_cycles),
    .off_cycles    (off_cycles),
    .repeat_cnt    (repeat_cnt),
    .pio_address   (pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n   (pio_write_n),
    .pio_writedata (pio_writedata),
    .busy          (busy),
    .done          (done),
    .pulses_done   (pulses_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PIO output register model: it resets to 1. Address 0 writes the data,
  // address 4 sets the bit and address 5 clears it.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pioOut <= 1'b1;
    end else if (pio_chipselect && !pio_write_n) begin
      case (pio_address)
        3'd0: pioOut <= pio_writedata[0];
        3'd4: if (pio_writedata[0]) pioOut <= 1'b1;
        3'd5: if (pio_writedata[0]) pioOut <= 1'b0;
        default: pioOut <= pioOut;
      endcase
    end
  end

  assign actBus = {pio_chipselect, pio_write_n, pio_address, pio_writedata};

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if (actBus !== BUS_IDLE) $display("[TB] FAIL reset_bus got %h want %h", actBus, BUS_IDLE);
    else passCount++;
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
    else passCount++;
    checkCount++;
    if (pulses_done !== '0) $display("[TB] FAIL reset_pulses got %0d want 0", pulses_done);
    else passCount++;
    checkCount++;
    if (pioOut !== 1'b1) $display("[TB] FAIL reset_pio got %b want 1", pioOut);
    else passCount++;
    reset_n = 1'b1;
    #1;
    checkCount++;
    if (actBus !== BUS_IDLE) $display("[TB] FAIL release_bus got %h want %h", actBus, BUS_IDLE);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (actBus !== BUS_INIT || busy !== 1'b1) $display("[TB] FAIL init_write got %h busy=%b want %h busy=1", actBus, busy, BUS_INIT);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (actBus !== BUS_IDLE || busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL init_idle got %h busy=%b done=%b want %h 0 0", actBus, busy, done, BUS_IDLE);
    else passCount++;
    checkCount++;
    if (pioOut !== 1'b0) $display("[TB] FAIL init_pio got %b want 0", pioOut);
    else passCount++;
  endtask

  // Full train with per-cycle expectations worked out from on/off/repeat.
  task automatic test_pulse_train(input int onIn, input int offIn, input int rep);
    int onE, offE, per, doneK, j;
    logic [36:0] expBus;
    logic expPio;
    onE   = (onIn == 0) ? 1 : onIn;
    offE  = (offIn == 0) ? 1 : offIn;
    per   = onE + offE;
    doneK = onE + (rep - 1) * per + 2;
    $display("[TB] pulse train on=%0d off=%0d rep=%0d", onIn, offIn, rep);
    on_cycles  = CNT_W'(onIn);
    off_cycles = CNT_W'(offIn);
    repeat_cnt = REP_W'(rep);
    start      = 1'b1;
    for (int k = 1; k <= doneK + 1; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      j = k - 1;
      expBus = BUS_IDLE;
      if ((j % per) == 0 && (j / per) < rep) expBus = BUS_SET;
      else if ((j % per) == onE && (j / per) < rep) expBus = BUS_CLR;
      checkCount++;
      if (actBus !== expBus) $display("[TB] FAIL train_bus k=%0d got %h want %h", k, actBus, expBus);
      else passCount++;
      expPio = (k >= 2) && (((k - 2) % per) < onE) && (((k - 2) / per) < rep);
      checkCount++;
      if (pioOut !== expPio) $display("[TB] FAIL train_pio k=%0d got %b want %b", k, pioOut, expPio);
      else passCount++;
      checkCount++;
      if (busy !== (k < doneK) || done !== (k == doneK))
        $display("[TB] FAIL train_flags k=%0d got busy=%b done=%b want %b %b", k, busy, done, (k < doneK), (k == doneK));
      else passCount++;
      if (k == 1 || k == doneK) begin
        checkCount++;
        if (pulses_done !== ((k == 1) ? REP_W'(0) : REP_W'(rep)))
          $display("[TB] FAIL train_pulses k=%0d got %0d want %0d", k, pulses_done, (k == 1) ? 0 : rep);
        else passCount++;
      end
    end
  endtask

  task automatic test_zero_repeat();
    on_cycles  = CNT_W'(5);
    off_cycles = CNT_W'(5);
    repeat_cnt = '0;
    start      = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      checkCount++;
      if (actBus !== BUS_IDLE) $display("[TB] FAIL zero_bus k=%0d got %h want %h", k, actBus, BUS_IDLE);
      else passCount++;
      checkCount++;
      if (busy !== (k == 1) || done !== (k == 1))
        $display("[TB] FAIL zero_flags k=%0d got busy=%b done=%b want %b %b", k, busy, done, (k == 1), (k == 1));
      else passCount++;
    end
    checkCount++;
    if (pulses_done !== '0) $display("[TB] FAIL zero_pulses got %0d want 0", pulses_done);
    else passCount++;
  endtask

  // on=10, off=3, repeat=5, period 13. The second set is at k=14, and abort
  // is raised in the 4th ON_WAIT cycle (k=18).
  task automatic test_abort();
    on_cycles  = CNT_W'(10);
    off_cycles = CNT_W'(3);
    repeat_cnt = REP_W'(5);
    start      = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 19) abort = 1'b0;
      if (k == 14) begin
        checkCount++;
        if (actBus !== BUS_SET) $display("[TB] FAIL abort_set2 got %h want %h", actBus, BUS_SET);
        else passCount++;
      end
      if (k == 18) begin
        checkCount++;
        if (actBus !== BUS_IDLE || pioOut !== 1'b1) $display("[TB] FAIL abort_wait got %h pio=%b want %h 1", actBus, pioOut, BUS_IDLE);
        else passCount++;
        abort = 1'b1;
      end
      if (k == 19) begin
        checkCount++;
        if (actBus !== BUS_CLR || done !== 1'b0) $display("[TB] FAIL abort_clear got %h done=%b want %h 0", actBus, done, BUS_CLR);
        else passCount++;
      end
      if (k == 20) begin
        checkCount++;
        if (done !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL abort_done got done=%b busy=%b want 1 0", done, busy);
        else passCount++;
        checkCount++;
        if (pulses_done !== REP_W'(2) || pioOut !== 1'b0) $display("[TB] FAIL abort_result got pulses=%0d pio=%b want 2 0", pulses_done, pioOut);
        else passCount++;
      end
      if (k == 21) begin
        checkCount++;
        if (actBus !== BUS_IDLE || done !== 1'b0) $display("[TB] FAIL abort_after got %h done=%b want %h 0", actBus, done, BUS_IDLE);
        else passCount++;
      end
    end
  endtask

  // on=2, off=3, repeat=3. The first clear is at k=3, OFF_WAIT at k=4..5 and
  // the next set at k=6. A stray start in OFF_WAIT must be ignored. Reset is
  // then dropped in the middle of ON_WAIT at k=7.
  task automatic test_busy_start_and_reset();
    on_cycles  = CNT_W'(2);
    off_cycles = CNT_W'(3);
    repeat_cnt = REP_W'(3);
    start      = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 4) start = 1'b1;
      if (k == 5) begin
        start = 1'b0;
        checkCount++;
        if (actBus !== BUS_IDLE || pulses_done !== REP_W'(1)) $display("[TB] FAIL busy_start got %h pulses=%0d want %h 1", actBus, pulses_done, BUS_IDLE);
        else passCount++;
      end
      if (k == 6) begin
        checkCount++;
        if (actBus !== BUS_SET) $display("[TB] FAIL busy_set2 got %h want %h", actBus, BUS_SET);
        else passCount++;
      end
    end
    checkCount++;
    if (pioOut !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL busy_onwait got pio=%b busy=%b want 1 1", pioOut, busy);
    else passCount++;
    #2 reset_n = 1'b0;
    #1;
    checkCount++;
    if (actBus !== BUS_IDLE) $display("[TB] FAIL midreset_bus got %h want %h", actBus, BUS_IDLE);
    else passCount++;
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0 || pulses_done !== '0) $display("[TB] FAIL midreset_flags got busy=%b done=%b pulses=%0d want 0 0 0", busy, done, pulses_done);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (actBus !== BUS_IDLE || busy !== 1'b0) $display("[TB] FAIL midreset_hold got %h busy=%b want %h 0", actBus, busy, BUS_IDLE);
    else passCount++;
    reset_n = 1'b1;
    @(negedge clk);
    checkCount++;
    if (actBus !== BUS_INIT) $display("[TB] FAIL reinit_write got %h want %h", actBus, BUS_INIT);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (actBus !== BUS_IDLE || busy !== 1'b0 || pioOut !== 1'b0) $display("[TB] FAIL reinit_idle got %h busy=%b pio=%b want %h 0 0", actBus, busy, pioOut, BUS_IDLE);
    else passCount++;
  endtask

  // A one-pulse train ends with done at k=3. A new start is given in that
  // done cycle and must be accepted straight away.
  task automatic test_back_to_back();
    on_cycles  = CNT_W'(1);
    off_cycles = CNT_W'(1);
    repeat_cnt = REP_W'(1);
    start      = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    checkCount++;
    if (done !== 1'b1) $display("[TB] FAIL b2b_done1 got %b want 1", done);
    else passCount++;
    on_cycles = CNT_W'(2);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkCount++;
    if (actBus !== BUS_SET || busy !== 1'b1 || pulses_done !== '0) $display("[TB] FAIL b2b_accept got %h busy=%b pulses=%0d want %h 1 0", actBus, busy, pulses_done, BUS_SET);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (actBus !== BUS_IDLE || pioOut !== 1'b1) $display("[TB] FAIL b2b_wait got %h pio=%b want %h 1", actBus, pioOut, BUS_IDLE);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (actBus !== BUS_CLR) $display("[TB] FAIL b2b_clear got %h want %h", actBus, BUS_CLR);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (done !== 1'b1 || pulses_done !== REP_W'(1)) $display("[TB] FAIL b2b_done2 got done=%b pulses=%0d want 1 1", done, pulses_done);
    else passCount++;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    start      = 1'b0;
    abort      = 1'b0;
    on_cycles  = '0;
    off_cycles = '0;
    repeat_cnt = '0;
    test_reset();
    test_pulse_train(3, 2, 3);
    test_pulse_train(0, 0, 2);
    test_zero_repeat();
    test_abort();
    test_busy_start_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
